// File: rtl/cmpl_mul_arbiter_pkg.sv
// Shared widths, tag type and pointer helper for the complex-multiplier arbiter.
package cmpl_mul_arbiter_pkg;
  localparam int DATA_W  = 18;
  localparam int PROD_W  = 36;
  localparam int ID_W    = 3;
  localparam int SIM_DLY = 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
    return (int'(v) >= n - 1) ? '0 : v + ID_W'(1);
  endfunction
endpackage

// File: rtl/cmpl_mul_arbiter_if.sv
// Requester, multiplier and response bundle; slave = arbiter view, master = environment view.
interface cmpl_mul_arbiter_if
  import cmpl_mul_arbiter_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][DATA_W-1:0] req_ar, req_ai, req_br, req_bi;
  logic [DATA_W-1:0]           mul_ar, mul_ai, mul_br, mul_bi;
  logic [PROD_W-1:0]           mul_result_real, mul_result_imag;
  logic [NREQ-1:0]             rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [PROD_W-1:0]           rsp_real, rsp_imag;

  modport slave (
    input  req_valid, req_ar, req_ai, req_br, req_bi, mul_result_real, mul_result_imag,
    output req_ready, mul_ar, mul_ai, mul_br, mul_bi, rsp_valid, rsp_id, rsp_real, rsp_imag
  );
  modport master (
    output req_valid, req_ar, req_ai, req_br, req_bi, mul_result_real, mul_result_imag,
    input  req_ready, mul_ar, mul_ai, mul_br, mul_bi, rsp_valid, rsp_id, rsp_real, rsp_imag
  );
endinterface

// File: rtl/cmpl_mul_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo NREQ.
module cmpl_mul_rr_pick
  import cmpl_mul_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;

  always_comb begin
    int off;
    int sum;
    off   = 0;
    sum   = 0;
    any_o = 1'b0;
    gnt_o = '0;
    // rotate so bit 0 is the pointer position; lowest set bit wins
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NREQ-1:0];
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr_i) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    idx_o = ID_W'(sum);
    for (int i = 0; i < NREQ; i++) gnt_o[i] = any_o && (idx_o == ID_W'(i));
  end
endmodule

// File: rtl/cmpl_mul_arbiter.sv
// Round-robin share of one pipelined complex multiplier; tags route results back.
// Optional burst grants with `define CMUL_ARB_BURST_EN.
module cmpl_mul_arbiter
  import cmpl_mul_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = 2,
  parameter int BURST_LEN = 4
) (
  input  logic               clock,
  input  logic               reset,
  cmpl_mul_arbiter_if.slave  bus
);
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be 2..8");
  end
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst
    $error("BURST_LEN must be 1..15");
  end
  if (MUL_LAT < 1) begin : g_bad_lat
    $error("MUL_LAT must be >= 1");
  end

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              fire;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] sel_ar, sel_ai, sel_br, sel_bi;
  logic [DATA_W-1:0] ar_q, ai_q, br_q, bi_q;
  tag_t              tag_new;
  tag_t [MUL_LAT:0]  tag_q;
  logic [NREQ-1:0]   rsp_oh, rsp_vld_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [PROD_W-1:0] re_q, im_q;

  cmpl_mul_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (fire)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    sel_ar = '0;
    sel_ai = '0;
    sel_br = '0;
    sel_bi = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_ar = bus.req_ar[i];
        sel_ai = bus.req_ai[i];
        sel_br = bus.req_br[i];
        sel_bi = bus.req_bi[i];
      end
    end
  end

  assign tag_new = '{vld: fire, id: gnt_idx};

  always_comb begin
    rsp_oh = '0;
    for (int i = 0; i < NREQ; i++) rsp_oh[i] = tag_q[MUL_LAT].vld && (tag_q[MUL_LAT].id == ID_W'(i));
  end

`ifdef CMUL_ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d, cnt_n;

  // pointer parks on the winner until it has had BURST_LEN back-to-back grants
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    cnt_n = 4'd1;
    if (fire) begin
      if (gnt_idx == ptr_q && cnt_q != 4'd0) cnt_n = cnt_q + 4'd1;
      if (cnt_n >= 4'(BURST_LEN)) begin
        ptr_d = wrap_inc(gnt_idx, NREQ);
        cnt_d = '0;
      end else begin
        ptr_d = gnt_idx;
        cnt_d = cnt_n;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign ptr_d = fire ? wrap_inc(gnt_idx, NREQ) : ptr_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= '0;
      ar_q      <= '0;
      ai_q      <= '0;
      br_q      <= '0;
      bi_q      <= '0;
      tag_q     <= '0;
      rsp_vld_q <= '0;
      rsp_id_q  <= '0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (fire) begin
        ar_q <= sel_ar;
        ai_q <= sel_ai;
        br_q <= sel_br;
        bi_q <= sel_bi;
      end
      tag_q     <= {tag_q[MUL_LAT-1:0], tag_new};
      rsp_vld_q <= rsp_oh;
      rsp_id_q  <= tag_q[MUL_LAT].id;
      re_q      <= bus.mul_result_real;
      im_q      <= bus.mul_result_imag;
    end
  end

  assign bus.mul_ar    = ar_q;
  assign bus.mul_ai    = ai_q;
  assign bus.mul_br    = br_q;
  assign bus.mul_bi    = bi_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_real  = re_q;
  assign bus.rsp_imag  = im_q;
endmodule
